// File: rtl/sync_fifo_ctrl.sv
// Single-clock parametrised FIFO with fill level, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module sync_fifo_ctrl #(
    parameter int unsigned DATA      = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = 14,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       winc,
    input  logic [DATA-1:0]            wdata,
    input  logic                       rinc,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic [DATA-1:0]            rdata,
    output logic                       wfull,
    output logic                       rempty,
    output logic                       walmost_full,
    output logic                       ralmost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

    logic [DATA-1:0] mem [DEPTH];

    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
    logic            wfull_q, wfull_d, rempty_q, rempty_d;
    logic            wafull_q, wafull_d, raempty_q, raempty_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA-1:0] rdata_q, rdata_d;
    logic            wr_acc, rd_acc;
    logic [AW-1:0]   waddr, raddr;

    assign waddr = wptr_q[AW-1:0];
    assign raddr = rptr_q[AW-1:0];

    always_comb begin
        // Flags are the registered pre-edge state, so no same-cycle bypass exists.
        wr_acc = winc && !wfull_q && !flush;
        rd_acc = rinc && !rempty_q && !flush;

        wptr_d = wptr_q + PW'(wr_acc);
        rptr_d = flush ? wptr_q : rptr_q + PW'(rd_acc);

        level_d   = wptr_d - rptr_d;
        wfull_d   = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
        rempty_d  = (wptr_d == rptr_d);
        wafull_d  = (level_d >= AFULL_LV);
        raempty_d = (level_d <= AEMPTY_LV);

        // Set wins over clear; flush suppresses setting.
        ovf_d = (winc && wfull_q && !flush) || (ovf_q && !clr_err);
        udf_d = (rinc && rempty_q && !flush) || (udf_q && !clr_err);

        rdata_d = rd_acc ? mem[raddr] : rdata_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            wfull_q   <= 1'b0;
            rempty_q  <= 1'b1;
            wafull_q  <= 1'b0;
            raempty_q <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            wfull_q   <= wfull_d;
            rempty_q  <= rempty_d;
            wafull_q  <= wafull_d;
            raempty_q <= raempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word shown directly; when empty, hold the last popped word.
    assign rdata = rempty_q ? rdata_q : mem[raddr];
`else
    assign rdata = rdata_q;
`endif

    assign wfull         = wfull_q;
    assign rempty        = rempty_q;
    assign walmost_full  = wafull_q;
    assign ralmost_empty = raempty_q;
    assign level         = level_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed + randomized bench for sync_fifo_ctrl against a queue-based reference model.
module tb_sync_fifo_ctrl;

    localparam int unsigned DATA   = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AFULL  = 14;
    localparam int unsigned AEMPTY = 2;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            winc = 1'b0, rinc = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DATA-1:0] wdata = '0;
    logic [DATA-1:0] rdata;
    logic            wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
    logic [LW-1:0]   level;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DATA-1:0] q[$];
    logic            m_ovf = 1'b0, m_udf = 1'b0;
    logic [DATA-1:0] m_last = '0;

    sync_fifo_ctrl #(
        .DATA(DATA), .DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)
    ) dut (
        .clk(clk), .rstn(rstn), .winc(winc), .wdata(wdata), .rinc(rinc),
        .flush(flush), .clr_err(clr_err), .rdata(rdata), .wfull(wfull),
        .rempty(rempty), .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA-1:0] exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
        if (q.size() > 0) return q[0];
`endif
        return m_last;
    endfunction

    task automatic chk_all(input string pfx);
        int n = q.size();
        chk({pfx, ".level"},  32'(level), n);
        chk({pfx, ".wfull"},  32'(wfull), 32'(n == DEPTH));
        chk({pfx, ".rempty"}, 32'(rempty), 32'(n == 0));
        chk({pfx, ".afull"},  32'(walmost_full), 32'(n >= AFULL));
        chk({pfx, ".aempty"}, 32'(ralmost_empty), 32'(n <= AEMPTY));
        chk({pfx, ".ovf"},    32'(overflow), 32'(m_ovf));
        chk({pfx, ".udf"},    32'(underflow), 32'(m_udf));
        chk({pfx, ".rdata"},  32'(rdata), 32'(exp_rdata()));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_last = '0;
    endtask

    // Drive one cycle, advance the model from pre-edge occupancy, check after the edge.
    task automatic step(input string pfx, input logic w, input logic [DATA-1:0] d,
                        input logic r, input logic f, input logic c);
        int  n = q.size();
        logic so, su;
        winc = w; wdata = d; rinc = r; flush = f; clr_err = c;
        so = 1'b0; su = 1'b0;
        if (f) begin
            q.delete();
        end else begin
            so = w && (n == DEPTH);
            su = r && (n == 0);
            if (r && n > 0) m_last = q.pop_front();
            if (w && n < DEPTH) q.push_back(d);
        end
        m_ovf = so || (m_ovf && !c);
        m_udf = su || (m_udf && !c);
        @(posedge clk);
        #1;
        chk_all(pfx);
        winc = 1'b0; rinc = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset");
        rstn = 1'b1;

        // Fill 0x01..0x10, then one dropped write
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DATA'(i), 1'b0, 1'b0, 1'b0);
        step("fill_ovf", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        chk("fill_ovf_const", 32'(overflow), 32'd1);

        // Drain, then one read past empty
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_order", 32'(rdata), 32'(i));
`endif
        end
        step("drain_udf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_udf_const", 32'(underflow), 32'd1);

        // Simultaneous read/write at level 8 across pointer wrap
        step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step("pre8", 1'b1, DATA'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("rw8", 1'b1, DATA'(8'h28 + i), 1'b1, 1'b0, 1'b0);
        chk("rw8_level", 32'(level), 32'd8);

        // Full + winc + rinc, then drain and empty + winc + rinc
        while (q.size() < DEPTH) step("tofull", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("full_rw_level", 32'(level), 32'd15);
        while (q.size() > 0) step("toempty", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("empty_rw", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_level", 32'(level), 32'd1);

        // Flush with concurrent write, then clear errors and round-trip 0xAA
        while (q.size() < 5) step("to5", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        step("clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step("wr_aa", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step("rd_aa", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("aa_roundtrip", 32'(rdata), 32'hAA);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 55), DATA'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset between edges at level 9 with winc active
        step("pre_ar_flush", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step("to9", 1'b1, DATA'($urandom), 1'b0, 1'b0, 1'b0);
        winc = 1'b1; wdata = 8'h42;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        @(posedge clk);
        #1;
        chk_all("async_rst_hold");
        winc = 1'b0;
        rstn = 1'b1;
        step("post_wr", 1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
        step("post_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("post_roundtrip", 32'(rdata), 32'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO: the single-clock generalisation of our async FIFO. Same winc/rinc/wfull/rempty handshake, plus:
- configurable width and depth
- fill-level output
- programmable almost-full / almost-empty flags
- sticky overflow/underflow error flags
- synchronous flush
Used inside one clock domain, and as the golden single-clock reference for async FIFO scoreboards.

Parameters:
DATA, 8, data word width in bits (≥1)
DEPTH, 16, number of entries; power of 2, ≥4
AFULL_TH, 14, walmost_full asserts when level ≥ AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, ralmost_empty asserts when level ≤ AEMPTY_TH (0..DEPTH-1)

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
winc  input  1  write request
wdata  input  DATA  write data
rinc  input  1  read request
flush  input  1  synchronous flush: empties FIFO, keeps error flags
clr_err  input  1  synchronous clear of overflow/underflow
rdata  output  DATA  read data
wfull  output  1  FIFO full
rempty  output  1  FIFO empty
walmost_full  output  1  level ≥ AFULL_TH
ralmost_empty  output  1  level ≤ AEMPTY_TH
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn).
- Reset (rstn=0, asynchronous): pointers=0, level=0, rdata=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=0, underflow=0. Memory contents not reset.
- Pointers: wptr/rptr are $clog2(DEPTH)+1 bits with an extra wrap bit. Address = low bits. Pointers wrap naturally at 2·DEPTH.
  - full: addresses equal, wrap bits differ.
  - empty: pointers equal.
- Write accepted at posedge iff winc && !wfull. Accepted write stores wdata at mem[waddr] and increments wptr.
- Read accepted at posedge iff rinc && !rempty. Accepted read increments rptr.
- Flags use registered pre-edge state. No same-cycle bypass:
  - Full + winc + rinc: read only. Write dropped, overflow set.
  - Empty + winc + rinc: write only. Read ignored, underflow set.
  - Otherwise simultaneous write+read: level unchanged.
- level, wfull, rempty, walmost_full, ralmost_empty are registered and computed from next-state pointers. They are valid the cycle after the causing edge.
- overflow set on winc && wfull; underflow set on rinc && rempty. Both hold until clr_err=1 at a posedge or reset. If set and clear coincide, set wins.
- flush=1 at posedge: rptr←wptr (contents discarded), level←0, rempty←1, wfull←0. Any winc/rinc in the same cycle is ignored and does not set error flags.
- Standard mode (macro undefined): rdata is a register loaded with mem[raddr] on an accepted read. Data is visible the cycle after the rinc edge and held until the next accepted read.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through): rdata = mem[raddr] whenever rempty=0, with no rinc needed. An accepted rinc pops the head, and the next word (if any) appears after that edge. rdata is undefined-but-stable (last head) when rempty=1. The first write into an empty FIFO is visible on rdata the cycle rempty falls.
- Undefined: standard registered-read mode as above.

Test Plan:
- Reset then fill: rstn low 3 cycles; write 0x01..0x10 (DEPTH=16). Expect:
  - level 1..16
  - wfull=1 after the 16th write
  - walmost_full=1 from level 14
  - 17th winc dropped, overflow=1
- Drain: 16 reads after fill. Expect:
  - rdata 0x01..0x10 in order (1-cycle latency standard, immediate in FWFT)
  - rempty=1 after last read, ralmost_empty=1 at level ≤2
  - extra rinc → underflow=1
- Simultaneous R/W at level 8 for 40 cycles with incrementing data. Expect:
  - level stays 8, pointers wrap past 31→0
  - output order preserved, no errors
- Boundary simultaneity: full + winc+rinc → level 15, wdata lost, overflow=1. Empty + winc+rinc → level 1, underflow=1.
- Flush and clear: level 5, flush+winc together → level 0, rempty=1, no overflow change. Then clr_err → overflow=underflow=0. Next write 0xAA reads back 0xAA.
- Async reset mid-operation: assert rstn low between edges at level 9 with winc active. All outputs go to reset values immediately, without waiting for clk. After release, the first write/read round-trips correctly.
